// File: rtl/lut_config_loader.sv
// Bit-serial configuration loader for a bank of LUTs: assembles LSB-first words and
// writes each one to the next LUT by pulsing its one-hot config enable for one cycle.
`timescale 1ns / 1ps

module lut_config_loader #(
  parameter int unsigned INPUTS   = 4,
  parameter int unsigned MEM_SIZE = 2 ** INPUTS,
  parameter int unsigned NUM_LUTS = 4
) (
  input  logic                cclk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                bit_ready,
  output logic [MEM_SIZE-1:0] config_out,
  output logic [NUM_LUTS-1:0] cen_out,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CntW = $clog2(MEM_SIZE + 1);
  localparam int unsigned IdxW = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [MEM_SIZE-1:0] sreg_q, sreg_d;
  logic [MEM_SIZE-1:0] word_q, word_d;
  logic [MEM_SIZE-1:0] sreg_shifted;
  logic                last_bit;
  logic                last_lut;

  // New bits enter at the top so the first accepted bit ends up in bit 0.
  assign sreg_shifted = {bit_in, sreg_q[MEM_SIZE-1:1]};
  assign last_bit     = (cnt_q == CntW'(MEM_SIZE - 1));
  assign last_lut     = (idx_q == IdxW'(NUM_LUTS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sreg_d  = sreg_q;
    word_d  = word_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StShift: begin
        if (bit_valid) begin
          sreg_d = sreg_shifted;
          cnt_d  = cnt_q + CntW'(1);
          if (last_bit) begin
            // Word is published on the same edge, so it is stable before the enable rises.
            word_d  = sreg_shifted;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (last_lut) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      sreg_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    cen_out = '0;
    for (int unsigned i = 0; i < NUM_LUTS; i++) begin
      cen_out[i] = (state_q == StWrite) && (idx_q == IdxW'(i));
    end
  end

  assign bit_ready  = (state_q == StShift);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign config_out = word_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Self-checking bench: default 16-bit x 4 loader plus a 4-bit x 1 instance, checked
// cycle by cycle against a protocol-level model and behavioural LUT memories.
`timescale 1ns / 1ps

module tb_lut_config_loader;

  logic cclk = 1'b0;
  always #5 cclk = ~cclk;

  logic        rst_n, start, bit_in, bit_valid;
  logic        bit_ready, busy, done;
  logic [15:0] config_out;
  logic [3:0]  cen_out;

  logic        start_b, bit_in_b, bit_valid_b;
  logic        bit_ready_b, busy_b, done_b;
  logic [3:0]  config_out_b;
  logic [0:0]  cen_out_b;

  lut_config_loader dut_a (
    .cclk       (cclk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .config_out (config_out),
    .cen_out    (cen_out),
    .busy       (busy),
    .done       (done)
  );

  lut_config_loader #(
    .INPUTS   (2),
    .NUM_LUTS (1)
  ) dut_b (
    .cclk       (cclk),
    .rst_n      (rst_n),
    .start      (start_b),
    .bit_in     (bit_in_b),
    .bit_valid  (bit_valid_b),
    .bit_ready  (bit_ready_b),
    .config_out (config_out_b),
    .cen_out    (cen_out_b),
    .busy       (busy_b),
    .done       (done_b)
  );

  // Behavioural LUT banks: each captures config_out on the edge its enable is high.
  logic [15:0] lut_a [4];
  logic [3:0]  lut_b;
  int          lut_wr_a = 0;

  always @(posedge cclk) begin
    for (int i = 0; i < 4; i++) if (cen_out[i]) lut_a[i] <= config_out;
    if (cen_out != 4'b0) lut_wr_a <= lut_wr_a + 1;
    if (cen_out_b[0]) lut_b <= config_out_b;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] words [4];
  logic [15:0] old_words [4];

  // One load sequence on dut_a. The model tracks only the stream position and the
  // handshake rules: a word's last accepted bit is followed by one write cycle, and the
  // write of the fourth word by one done cycle. abort_at >= 0 resets once that many bits
  // have been accepted.
  task automatic load_a(input string name, input int pct, input bit poke, input int abort_at,
                        output int done_cyc);
    int pos, cyc;
    bit exp_wr, exp_done, prev_wr, acc, fin;
    done_cyc  = -1;
    start     = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    @(posedge cclk); #1;
    start     = 1'b0;
    pos       = 0;
    cyc       = 0;
    exp_wr    = 1'b0;
    exp_done  = 1'b0;
    fin       = 1'b0;
    bit_in    = words[0][0];
    bit_valid = ($urandom_range(99) < pct);
    while (!fin && cyc < 3000) begin
      @(negedge cclk);
      check({name, ":bit_ready"}, bit_ready, !exp_wr && !exp_done);
      check({name, ":busy"}, busy, 1'b1);
      check({name, ":done"}, done, exp_done);
      check({name, ":cen_out"}, cen_out, exp_wr ? (4'b0001 << (pos / 16 - 1)) : 4'b0000);
      if (exp_wr) check({name, ":config_out"}, config_out, words[pos / 16 - 1]);
      if (exp_done) begin
        done_cyc = cyc;
        fin      = 1'b1;
      end else if (abort_at >= 0 && pos == abort_at) begin
        rst_n = 1'b0;
        @(posedge cclk); #1;
        @(negedge cclk);
        check({name, ":abort_busy"}, busy, 1'b0);
        check({name, ":abort_ready"}, bit_ready, 1'b0);
        check({name, ":abort_cen"}, cen_out, 4'b0000);
        rst_n     = 1'b1;
        bit_valid = 1'b0;
        @(posedge cclk); #1;
        return;
      end else begin
        acc = !exp_wr && bit_valid;
        @(posedge cclk); #1;
        cyc++;
        prev_wr   = exp_wr;
        if (acc) pos++;
        exp_wr    = acc && (pos % 16 == 0);
        exp_done  = prev_wr && (pos == 64);
        bit_in    = (pos < 64) ? words[pos / 16][pos % 16] : 1'b0;
        bit_valid = ($urandom_range(99) < pct);
        // Start pulses mid-shift of LUT 2 and in every write cycle must be ignored.
        start     = poke && acc && (pos == 40 || pos % 16 == 0);
      end
    end
    check({name, ":no_timeout"}, fin, 1'b1);
    start     = 1'b0;
    bit_valid = 1'b0;
    @(posedge cclk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge cclk);
      check({name, ":idle_busy"}, busy, 1'b0);
      check({name, ":idle_done"}, done, 1'b0);
      check({name, ":idle_cen"}, cen_out, 4'b0000);
      @(posedge cclk); #1;
    end
  endtask

  task automatic check_luts(input string name);
    for (int i = 0; i < 4; i++) check({name, ":lut"}, lut_a[i], words[i]);
  endtask

  initial begin
    int dc, wr0;
    logic [3:0] wb;

    rst_n       = 1'b0;
    start       = 1'b1;
    bit_valid   = 1'b1;
    bit_in      = 1'b1;
    start_b     = 1'b1;
    bit_valid_b = 1'b1;
    bit_in_b    = 1'b1;
    repeat (3) @(posedge cclk);
    #1;
    @(negedge cclk);
    check("rst:bit_ready", bit_ready, 1'b0);
    check("rst:busy", busy, 1'b0);
    check("rst:done", done, 1'b0);
    check("rst:cen_out", cen_out, 4'b0000);
    check("rst:config_out", config_out, 16'h0000);
    check("rst:lut_writes", lut_wr_a, 0);
    check("rst_b:busy", busy_b, 1'b0);
    check("rst_b:config_out", config_out_b, 4'h0);
    rst_n       = 1'b1;
    start       = 1'b0;
    bit_valid   = 1'b0;
    start_b     = 1'b0;
    bit_valid_b = 1'b0;
    bit_in_b    = 1'b0;
    @(posedge cclk); #1;

    words = '{16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF};
    load_a("full", 100, 1'b0, -1, dc);
    check("full:done_edge", dc, 68);
    check_luts("full");
    check("full:lut_writes", lut_wr_a, 4);

    load_a("stall", 50, 1'b0, -1, dc);
    check_luts("stall");
    check("stall:lut_writes", lut_wr_a, 8);

    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    load_a("poke", 100, 1'b1, -1, dc);
    check("poke:done_edge", dc, 68);
    check_luts("poke");
    check("poke:lut_writes", lut_wr_a, 12);

    old_words = words;
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    wr0 = lut_wr_a;
    load_a("abort", 100, 1'b0, 25, dc);
    check("abort:lut0_new", lut_a[0], words[0]);
    check("abort:lut1_kept", lut_a[1], old_words[1]);
    check("abort:lut_writes", lut_wr_a - wr0, 1);
    load_a("reload", 70, 1'b0, -1, dc);
    check_luts("reload");

    // Single 4-bit LUT: word 4'b1001 sent LSB-first.
    wb      = 4'b1001;
    start_b = 1'b1;
    @(posedge cclk); #1;
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bit_in_b    = wb[k];
      bit_valid_b = 1'b1;
      @(negedge cclk);
      check("small:bit_ready", bit_ready_b, 1'b1);
      check("small:cen_early", cen_out_b, 1'b0);
      @(posedge cclk); #1;
    end
    bit_valid_b = 1'b0;
    @(negedge cclk);
    check("small:cen", cen_out_b, 1'b1);
    check("small:config_out", config_out_b, 4'b1001);
    check("small:done_early", done_b, 1'b0);
    @(posedge cclk); #1;
    @(negedge cclk);
    check("small:done", done_b, 1'b1);
    check("small:cen_once", cen_out_b, 1'b0);
    check("small:lut", lut_b, 4'b1001);
    @(posedge cclk); #1;
    @(negedge cclk);
    check("small:busy_low", busy_b, 1'b0);
    check("small:done_once", done_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
